// File: rtl/spatz_boot_sequencer.sv
// Boots a set of clusters: settle delay, one boot-control write per cluster over reqrsp,
// then a msip wake pulse to every core. Single outstanding request, no REQ timeout.
module spatz_boot_sequencer #(
  parameter int unsigned NumClusters    = 1,
  parameter int unsigned NumCores       = 2,
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 64,
  parameter logic [63:0] PeriBaseAddr   = 64'h0,
  parameter logic [63:0] ClusterStride  = 64'h40_0000,
  parameter logic [63:0] BootCtrlOffset = 64'h0,
  parameter int unsigned BootDelay      = 1000,
  parameter int unsigned WakeCycles     = 1,
  parameter int unsigned TimeoutCycles  = 256,
  localparam int unsigned IdxWidth      = (NumClusters > 1) ? $clog2(NumClusters) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic [31:0]                     entry_point_i,
  output logic                            q_valid_o,
  input  logic                            q_ready_i,
  output logic [AddrWidth-1:0]            q_addr_o,
  output logic [DataWidth-1:0]            q_data_o,
  output logic                            q_write_o,
  output logic [DataWidth/8-1:0]          q_strb_o,
  input  logic                            p_valid_i,
  output logic                            p_ready_o,
  input  logic                            p_error_i,
  output logic [NumClusters*NumCores-1:0] msip_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            error_o,
  output logic [IdxWidth-1:0]             err_cluster_o
);

  localparam int unsigned MaxA     = (BootDelay > WakeCycles) ? BootDelay : WakeCycles;
  localparam int unsigned MaxCnt   = (MaxA > TimeoutCycles) ? MaxA : TimeoutCycles;
  localparam int unsigned CntWidth = $clog2(MaxCnt + 1);

  localparam logic [CntWidth-1:0]  DelayInit   = CntWidth'(BootDelay);
  localparam logic [CntWidth-1:0]  WakeInit    = CntWidth'(WakeCycles);
  localparam logic [CntWidth-1:0]  TimeoutLast = CntWidth'(TimeoutCycles - 1);
  localparam logic [CntWidth-1:0]  CntOne      = CntWidth'(1);
  localparam logic [IdxWidth-1:0]  LastIdx     = IdxWidth'(NumClusters - 1);
  // Address arithmetic wraps at AddrWidth by truncation.
  localparam logic [AddrWidth-1:0] FirstAddr   = AddrWidth'(PeriBaseAddr + BootCtrlOffset);
  localparam logic [AddrWidth-1:0] Stride      = AddrWidth'(ClusterStride);

  typedef enum logic [2:0] {IDLE, DELAY, REQ, RESP, WAKE, DONE, ERR} state_e;

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [IdxWidth-1:0]  idx_q, idx_d;
  logic [IdxWidth-1:0]  err_idx_q, err_idx_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [31:0]          entry_q, entry_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      err_idx_q <= '0;
      addr_q    <= '0;
      entry_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      err_idx_q <= err_idx_d;
      addr_q    <= addr_d;
      entry_q   <= entry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_idx_d = err_idx_q;
    addr_d    = addr_q;
    entry_d   = entry_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          entry_d   = entry_point_i;
          err_idx_d = '0;
          idx_d     = '0;
          addr_d    = FirstAddr;
          cnt_d     = DelayInit;
          state_d   = (BootDelay == 0) ? REQ : DELAY;
        end
      end
      DELAY: begin
        // Leave after BootDelay cycles so the first request trails start by BootDelay+1.
        if (cnt_q == CntOne) begin
          cnt_d   = '0;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      REQ: begin
        if (q_ready_i) begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        // A response on the expiry cycle wins over the timeout.
        if (p_valid_i) begin
          if (p_error_i) begin
            err_idx_d = idx_q;
            state_d   = ERR;
          end else if (idx_q == LastIdx) begin
            cnt_d   = WakeInit;
            state_d = WAKE;
          end else begin
            idx_d   = idx_q + 1'b1;
            addr_d  = addr_q + Stride;
            state_d = REQ;
          end
        end else if (cnt_q == TimeoutLast) begin
          err_idx_d = idx_q;
          state_d   = ERR;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      WAKE: begin
        if (cnt_q == CntOne) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign q_valid_o     = (state_q == REQ);
  assign q_addr_o      = addr_q;
  assign q_data_o      = DataWidth'(entry_q);
  assign q_write_o     = q_valid_o;
  assign q_strb_o      = {(DataWidth/8){q_valid_o}};
  assign p_ready_o     = (state_q == RESP);
  assign msip_o        = {(NumClusters*NumCores){state_q == WAKE}};
  assign busy_o        = (state_q == DELAY) || (state_q == REQ) || (state_q == RESP) ||
                         (state_q == WAKE);
  assign done_o        = (state_q == DONE);
  assign error_o       = (state_q == ERR);
  assign err_cluster_o = err_idx_q;

endmodule

// File: tb/tb_spatz_boot_sequencer.sv
// Directed bench: a four-cluster sequencer (delay 3, wake 3, timeout 8) and a single-cluster one.
module tb_spatz_boot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, q_valid, q_ready, q_write, p_valid, p_ready, p_error, busy, done, error;
  logic [31:0] entry;
  logic [47:0] q_addr;
  logic [63:0] q_data;
  logic [7:0]  q_strb, msip;
  logic [1:0]  err_cluster;

  logic        start1, q_valid1, q_ready1, q_write1, p_valid1, p_ready1, p_error1;
  logic        busy1, done1, error1;
  logic [31:0] entry1;
  logic [47:0] q_addr1;
  logic [63:0] q_data1;
  logic [7:0]  q_strb1;
  logic [1:0]  msip1;
  logic [0:0]  err_cluster1;

  int checks = 0;
  int errors = 0;

  spatz_boot_sequencer #(
    .NumClusters(4), .NumCores(2), .AddrWidth(48), .DataWidth(64),
    .PeriBaseAddr(64'h0), .ClusterStride(64'h40_0000), .BootCtrlOffset(64'h0),
    .BootDelay(3), .WakeCycles(3), .TimeoutCycles(8)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .entry_point_i(entry),
    .q_valid_o(q_valid), .q_ready_i(q_ready), .q_addr_o(q_addr), .q_data_o(q_data),
    .q_write_o(q_write), .q_strb_o(q_strb), .p_valid_i(p_valid), .p_ready_o(p_ready),
    .p_error_i(p_error), .msip_o(msip), .busy_o(busy), .done_o(done), .error_o(error),
    .err_cluster_o(err_cluster)
  );

  spatz_boot_sequencer #(
    .NumClusters(1), .NumCores(2), .AddrWidth(48), .DataWidth(64),
    .PeriBaseAddr(64'h0), .ClusterStride(64'h40_0000), .BootCtrlOffset(64'h100),
    .BootDelay(3), .WakeCycles(1), .TimeoutCycles(256)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .entry_point_i(entry1),
    .q_valid_o(q_valid1), .q_ready_i(q_ready1), .q_addr_o(q_addr1), .q_data_o(q_data1),
    .q_write_o(q_write1), .q_strb_o(q_strb1), .p_valid_i(p_valid1), .p_ready_o(p_ready1),
    .p_error_i(p_error1), .msip_o(msip1), .busy_o(busy1), .done_o(done1), .error_o(error1),
    .err_cluster_o(err_cluster1)
  );

  // Called on a falling edge; returns on the falling edge after start was sampled.
  task automatic do_start(input logic [31:0] ep);
    start = 1'b1;
    entry = ep;
    @(negedge clk);
    start = 1'b0;
    entry = 32'h0;
  endtask

  task automatic wait_q(output int n);
    n = 0;
    while (q_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Grants every request and answers every response slot without error.
  task automatic finish_boot();
    int n;
    n = 0;
    q_ready = 1'b1;
    p_error = 1'b0;
    while (done !== 1'b1 && error !== 1'b1 && n < 200) begin
      p_valid = p_ready;
      @(negedge clk);
      n++;
    end
    p_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({q_valid, q_write, q_strb, p_ready, msip, busy, done, error, err_cluster} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got %0h exp 0",
               {q_valid, q_write, q_strb, p_ready, msip, busy, done, error, err_cluster});
    end
    checks++;
    if ({q_addr, q_data} !== '0) begin
      errors++;
      $display("FAIL reset_addr_data got %0h exp 0", {q_addr, q_data});
    end
    checks++;
    if ({q_valid1, q_strb1, p_ready1, msip1, busy1, done1, error1, err_cluster1} !== '0) begin
      errors++;
      $display("FAIL reset_single got %0h exp 0",
               {q_valid1, q_strb1, p_ready1, msip1, busy1, done1, error1, err_cluster1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got %b%b exp 00", busy, busy1);
    end
  endtask

  task automatic test_single_cluster();
    int n;
    q_ready1 = 1'b1;
    start1   = 1'b1;
    entry1   = 32'h8000_0000;
    @(negedge clk);
    start1 = 1'b0;
    entry1 = 32'h0;
    n = 1;
    while (q_valid1 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL single_latency got %0d exp 4", n);
    end
    checks++;
    if (q_addr1 !== 48'h100 || q_data1 !== 64'h0000_0000_8000_0000) begin
      errors++;
      $display("FAIL single_write got addr %0h data %0h exp 100 80000000", q_addr1, q_data1);
    end
    checks++;
    if (q_write1 !== 1'b1 || q_strb1 !== 8'hFF) begin
      errors++;
      $display("FAIL single_wr_strb got %b %0h exp 1 ff", q_write1, q_strb1);
    end
    @(negedge clk);
    checks++;
    if (p_ready1 !== 1'b1 || q_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL single_resp got p_ready %b q_valid %b exp 1 0", p_ready1, q_valid1);
    end
    p_valid1 = 1'b1;
    @(negedge clk);
    p_valid1 = 1'b0;
    checks++;
    if (msip1 !== 2'b11 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL single_wake got msip %b busy %b exp 11 1", msip1, busy1);
    end
    @(negedge clk);
    checks++;
    if (msip1 !== 2'b00 || done1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL single_done got msip %b done %b busy %b exp 00 1 0", msip1, done1, busy1);
    end
  endtask

  task automatic test_boot_four();
    int n;
    logic [47:0] exp_addr [4];
    exp_addr = '{48'h0, 48'h40_0000, 48'h80_0000, 48'hC0_0000};
    q_ready = 1'b1;
    do_start(32'h1234_5678);
    for (int k = 0; k < 4; k++) begin
      wait_q(n);
      if (k == 0) begin
        checks++;
        if (n + 1 !== 4) begin
          errors++;
          $display("FAIL boot_latency got %0d exp 4", n + 1);
        end
      end
      checks++;
      if (q_valid !== 1'b1 || q_addr !== exp_addr[k] || q_data !== 64'h1234_5678) begin
        errors++;
        $display("FAIL boot_write%0d got v %b addr %0h data %0h exp 1 %0h 12345678",
                 k, q_valid, q_addr, q_data, exp_addr[k]);
      end
      @(negedge clk);
      checks++;
      if (p_ready !== 1'b1 || msip !== 8'h00) begin
        errors++;
        $display("FAIL boot_resp%0d got p_ready %b msip %0h exp 1 0", k, p_ready, msip);
      end
      p_valid = 1'b1;
      @(negedge clk);
      p_valid = 1'b0;
    end
    n = 0;
    while (msip === 8'hFF && n < 10) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL boot_wake_len got %0d exp 3", n);
    end
    checks++;
    if (msip !== 8'h00 || done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL boot_done got msip %0h done %b error %b exp 0 1 0", msip, done, error);
    end
  endtask

  task automatic test_stall();
    int n;
    int bad;
    q_ready = 1'b0;
    do_start(32'hA5A5_0001);
    wait_q(n);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (q_valid !== 1'b1 || q_addr !== 48'h0 || q_data !== 64'hA5A5_0001) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_stable got %0d unstable cycles exp 0", bad);
    end
    q_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (q_valid !== 1'b0 || p_ready !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got v %b p_ready %b err %b exp 0 1 0", q_valid, p_ready, error);
    end
    finish_boot();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done got %b exp 1", done);
    end
  endtask

  task automatic test_error();
    int k;
    int n;
    bit msip_seen;
    q_ready = 1'b1;
    do_start(32'h0000_2000);
    k = 0;
    n = 0;
    msip_seen = 1'b0;
    while (error !== 1'b1 && n < 100) begin
      if (msip !== 8'h00) msip_seen = 1'b1;
      if (p_ready === 1'b1) begin
        p_valid = 1'b1;
        p_error = (k == 2);
        k++;
      end else begin
        p_valid = 1'b0;
        p_error = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    p_valid = 1'b0;
    p_error = 1'b0;
    checks++;
    if (error !== 1'b1 || err_cluster !== 2'd2 || k !== 3) begin
      errors++;
      $display("FAIL err_cluster got err %b idx %0d resp %0d exp 1 2 3", error, err_cluster, k);
    end
    checks++;
    if (msip_seen !== 1'b0 || msip !== 8'h00 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_no_wake got seen %b done %b busy %b exp 0 0 0", msip_seen, done, busy);
    end
    p_valid = 1'b1;
    p_error = 1'b1;
    repeat (3) @(negedge clk);
    p_valid = 1'b0;
    p_error = 1'b0;
    checks++;
    if (error !== 1'b1 || err_cluster !== 2'd2 || p_ready !== 1'b0 || q_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky got err %b idx %0d p_ready %b exp 1 2 0", error, err_cluster, p_ready);
    end
  endtask

  task automatic test_timeout();
    int n;
    q_ready = 1'b1;
    p_valid = 1'b0;
    do_start(32'h0000_3000);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clears got err %b busy %b exp 0 1", error, busy);
    end
    wait_q(n);
    @(negedge clk);
    n = 0;
    while (p_ready === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 8 || error !== 1'b1 || err_cluster !== 2'd0) begin
      errors++;
      $display("FAIL timeout got %0d cycles err %b idx %0d exp 8 1 0", n, error, err_cluster);
    end
    do_start(32'h0000_3001);
    wait_q(n);
    @(negedge clk);
    repeat (7) @(negedge clk);
    checks++;
    if (p_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_edge_ready got %b exp 1", p_ready);
    end
    p_valid = 1'b1;
    @(negedge clk);
    p_valid = 1'b0;
    checks++;
    if (error !== 1'b0 || q_valid !== 1'b1 || q_addr !== 48'h40_0000) begin
      errors++;
      $display("FAIL timeout_edge_resp got err %b v %b addr %0h exp 0 1 400000", error, q_valid, q_addr);
    end
    finish_boot();
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_edge_done got done %b err %b exp 1 0", done, error);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    q_ready = 1'b1;
    do_start(32'h0000_4000);
    wait_q(n);
    @(negedge clk);
    checks++;
    if (p_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_resp got %b exp 1", p_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({q_valid, p_ready, msip, busy, done, error, err_cluster} !== '0) begin
      errors++;
      $display("FAIL mid_reset got %0h exp 0", {q_valid, p_ready, msip, busy, done, error, err_cluster});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(32'hCAFE_0000);
    start = 1'b1;
    entry = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    entry = 32'h0;
    checks++;
    if (busy !== 1'b1 || q_valid !== 1'b0) begin
      errors++;
      $display("FAIL reboot_busy got busy %b v %b exp 1 0", busy, q_valid);
    end
    wait_q(n);
    checks++;
    if (n + 2 !== 4 || q_data !== 64'hCAFE_0000 || q_addr !== 48'h0) begin
      errors++;
      $display("FAIL reboot_first got lat %0d data %0h addr %0h exp 4 cafe0000 0", n + 2, q_data, q_addr);
    end
    finish_boot();
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL reboot_done got done %b err %b exp 1 0", done, error);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    entry    = 32'h0;
    q_ready  = 1'b0;
    p_valid  = 1'b0;
    p_error  = 1'b0;
    start1   = 1'b0;
    entry1   = 32'h0;
    q_ready1 = 1'b0;
    p_valid1 = 1'b0;
    p_error1 = 1'b0;
    test_reset();
    test_single_cluster();
    test_boot_four();
    test_stall();
    test_error();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
